// File: rtl/alavanca2serial_if.sv
// Lever-link transmit bus: start request, lever values, UART line and status.
// The sender side drives start/levers; the transmitter drives TX and status.
interface alavanca2serial_if;
    logic        start;
    logic [15:0] al1Bits;
    logic [15:0] al2Bits;
    logic        TX;
    logic        busy;
    logic        done;
    logic [3:0]  db_estado;

    modport master (
        output start, al1Bits, al2Bits,
        input  TX, busy, done, db_estado
    );

    modport slave (
        input  start, al1Bits, al2Bits,
        output TX, busy, done, db_estado
    );
endinterface

// File: rtl/alavanca2serial.sv
// 8N1 UART transmitter sending HEADER plus the two signed lever values as one packet.
// Optional macro ALAVANCA_TX_CHECKSUM_EN appends an XOR checksum of the four data bytes.
module alavanca2serial #(
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [7:0]  HEADER       = 8'hA5
) (
    input  logic              clock,
    input  logic              reset,
    alavanca2serial_if.slave  bus
);
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
`ifdef ALAVANCA_TX_CHECKSUM_EN
    localparam logic [2:0] LAST_BYTE = 3'd5;
`else
    localparam logic [2:0] LAST_BYTE = 3'd4;
`endif

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_LOAD      = 4'd1,
        S_START_BIT = 4'd2,
        S_DATA_BITS = 4'd3,
        S_STOP_BIT  = 4'd4,
        S_NEXT_BYTE = 4'd5,
        S_DONE      = 4'd6
    } state_t;

    state_t              r_state, w_state_next;
    logic [BAUD_W-1:0]   r_baud, w_baud_next;
    logic [2:0]          r_bit, w_bit_next;
    logic [2:0]          r_byte, w_byte_next;
    logic [7:0]          r_shift, w_shift_next;
    logic [15:0]         r_al1, w_al1_next;
    logic [15:0]         r_al2, w_al2_next;
    logic                w_tx, w_busy, w_done;
    logic                w_baud_last;
    logic [2:0]          w_sel_idx;
    logic [7:0]          w_sel_byte;

    assign w_baud_last = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));

    // The stop bit preloads the following byte so start bits follow back to back.
    assign w_sel_idx = (r_state == S_STOP_BIT) ? (r_byte + 3'd1) : r_byte;

`ifdef ALAVANCA_TX_CHECKSUM_EN
    logic [7:0] w_checksum;
    assign w_checksum = r_al1[15:8] ^ r_al1[7:0] ^ r_al2[15:8] ^ r_al2[7:0];
`endif

    always_comb begin
        w_sel_byte = HEADER;
        case (w_sel_idx)
            3'd0:    w_sel_byte = HEADER;
            3'd1:    w_sel_byte = r_al1[15:8];
            3'd2:    w_sel_byte = r_al1[7:0];
            3'd3:    w_sel_byte = r_al2[15:8];
            3'd4:    w_sel_byte = r_al2[7:0];
`ifdef ALAVANCA_TX_CHECKSUM_EN
            3'd5:    w_sel_byte = w_checksum;
`endif
            default: w_sel_byte = HEADER;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_byte  <= '0;
            r_shift <= '0;
            r_al1   <= '0;
            r_al2   <= '0;
        end else begin
            r_baud  <= w_baud_next;
            r_bit   <= w_bit_next;
            r_byte  <= w_byte_next;
            r_shift <= w_shift_next;
            r_al1   <= w_al1_next;
            r_al2   <= w_al2_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud;
        w_bit_next   = r_bit;
        w_byte_next  = r_byte;
        w_shift_next = r_shift;
        w_al1_next   = r_al1;
        w_al2_next   = r_al2;
        w_tx         = 1'b1;
        w_busy       = 1'b0;
        w_done       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_al1_next   = bus.al1Bits;
                    w_al2_next   = bus.al2Bits;
                    w_byte_next  = '0;
                    w_bit_next   = '0;
                    w_baud_next  = '0;
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_busy       = 1'b1;
                w_shift_next = w_sel_byte;
                w_baud_next  = '0;
                w_state_next = S_START_BIT;
            end
            S_START_BIT: begin
                w_busy = 1'b1;
                w_tx   = 1'b0;
                if (w_baud_last) begin
                    w_baud_next  = '0;
                    w_bit_next   = '0;
                    w_state_next = S_DATA_BITS;
                end else begin
                    w_baud_next = r_baud + BAUD_W'(1);
                end
            end
            S_DATA_BITS: begin
                w_busy = 1'b1;
                w_tx   = r_shift[0];
                if (w_baud_last) begin
                    w_baud_next  = '0;
                    w_shift_next = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        w_state_next = S_STOP_BIT;
                    end else begin
                        w_bit_next = r_bit + 3'd1;
                    end
                end else begin
                    w_baud_next = r_baud + BAUD_W'(1);
                end
            end
            S_STOP_BIT: begin
                w_busy = 1'b1;
                if (w_baud_last) begin
                    w_baud_next = '0;
                    if (r_byte == LAST_BYTE) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_byte_next  = r_byte + 3'd1;
                        w_shift_next = w_sel_byte;
                        w_state_next = S_START_BIT;
                    end
                end else begin
                    w_baud_next = r_baud + BAUD_W'(1);
                end
            end
            S_NEXT_BYTE: begin
                // Normally bypassed by the stop-bit preload; kept as a safe reload path.
                w_busy       = 1'b1;
                w_shift_next = w_sel_byte;
                w_baud_next  = '0;
                w_state_next = S_START_BIT;
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign bus.TX        = w_tx;
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.db_estado = r_state;
endmodule

// File: tb/tb_alavanca2serial.sv
// Randomised scoreboard bench: stimulus pushes expected bytes/frame lengths, a UART monitor checks them.
module tb_alavanca2serial;
    localparam int         CPB = 4;
    localparam logic [7:0] HDR = 8'hA5;
`ifdef ALAVANCA_TX_CHECKSUM_EN
    localparam int NB = 6;
`else
    localparam int NB = 5;
`endif
    localparam int FRAME = NB * 10 * CPB;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alavanca2serial_if bus();

    alavanca2serial #(.CLKS_PER_BIT(CPB), .HEADER(HDR)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];
    int         exp_len_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s", name);
    endtask

    // Reference: header, big-endian levers, optional XOR of the four data bytes.
    function automatic void model_push(input logic [15:0] a1, input logic [15:0] a2);
        int b[6];
        b[0] = HDR;
        b[1] = (a1 >> 8) & 255;
        b[2] = a1 & 255;
        b[3] = (a2 >> 8) & 255;
        b[4] = a2 & 255;
        b[5] = b[1] ^ b[2] ^ b[3] ^ b[4];
        for (int i = 0; i < NB; i++) exp_q.push_back(8'(b[i]));
        exp_len_q.push_back(NB * 10 * CPB);
    endfunction

    // Monitor: UART decode at mid-bit, frame length and busy checks at done.
    int         cyc = 0;
    int         rx_cnt = -1;
    int         frame_start = 0;
    int         busy_lows = 0;
    bit         pkt_active = 1'b0;
    logic [7:0] rx_byte = '0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            rx_cnt     = -1;
            pkt_active = 1'b0;
        end else begin
            if (pkt_active && !bus.done && !bus.busy) busy_lows++;
            if (rx_cnt < 0) begin
                if (bus.TX == 1'b0) begin
                    rx_cnt = 0;
                    if (!pkt_active) begin
                        pkt_active  = 1'b1;
                        frame_start = cyc;
                        busy_lows   = 0;
                    end
                end
            end else begin
                rx_cnt++;
                if (rx_cnt == CPB / 2) begin
                    check("start_bit", 32'(bus.TX), 32'd0);
                end else if (rx_cnt > CPB / 2 && rx_cnt < CPB / 2 + 9 * CPB
                             && ((rx_cnt - CPB / 2) % CPB) == 0) begin
                    rx_byte[(rx_cnt - CPB / 2) / CPB - 1] = bus.TX;
                end else if (rx_cnt == CPB / 2 + 9 * CPB) begin
                    check("stop_bit", 32'(bus.TX), 32'd1);
                    if (exp_q.size() == 0) flag("unexpected_byte");
                    else check("tx_byte", 32'(rx_byte), 32'(exp_q.pop_front()));
                    $display("byte rx %02h at cycle %0d", rx_byte, cyc);
                    rx_cnt = -1;
                end
            end
            if (bus.done) begin
                if (exp_len_q.size() == 0 || !pkt_active) begin
                    flag("unexpected_done");
                end else begin
                    check("frame_len", 32'(cyc - frame_start), 32'(exp_len_q.pop_front()));
                    check("busy_in_frame", 32'(busy_lows), 32'd0);
                    check("busy_at_done", 32'(bus.busy), 32'd0);
                end
                $display("packet done at cycle %0d", cyc);
                pkt_active = 1'b0;
            end
        end
    end

    task automatic issue_start(input logic [15:0] a1, input logic [15:0] a2, input bit accept);
        @(posedge clk);
        #1;
        bus.start   = 1'b1;
        bus.al1Bits = a1;
        bus.al2Bits = a2;
        if (accept) model_push(a1, a2);
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.al1Bits = 16'($urandom);
        bus.al2Bits = 16'($urandom);
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < FRAME + 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        check("done_seen", 32'(seen), 32'd1);
    endtask

    task automatic send(input logic [15:0] a1, input logic [15:0] a2);
        issue_start(a1, a2, 1'b1);
        wait_done();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start   = 1'b0;
        bus.al1Bits = '0;
        bus.al2Bits = '0;
        rst_n       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_tx", 32'(bus.TX), 32'd1);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_state", 32'(bus.db_estado), 32'd0);

        // start during reset is ignored
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        check("reset_beats_start", 32'(bus.db_estado), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        send(16'h1234, 16'hFEDC);
        send(16'h8000, 16'hFFFF);

        // re-pulse and input change mid-packet: only the first packet goes out
        issue_start(16'h1111, 16'h2222, 1'b1);
        repeat (50) @(posedge clk);
        issue_start(16'h3333, 16'h4444, 1'b0);
        wait_done();

        // start while in DONE is dropped
        bus.start   = 1'b1;
        bus.al1Bits = 16'h5555;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (60) @(negedge clk);
        check("idle_after_done_start", 32'(bus.db_estado), 32'd0);
        check("idle_tx_high", 32'(bus.TX), 32'd1);

        for (int k = 0; k < 8; k++) begin
            send(16'($urandom), 16'($urandom));
            repeat ($urandom_range(0, 5)) @(posedge clk);
        end

        // reset during data bits of byte 2 aborts the packet
        issue_start(16'hABCD, 16'h0123, 1'b1);
        repeat (95) @(posedge clk);
        @(negedge clk);
        check("pre_reset_state", 32'(bus.db_estado), 32'd3);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        exp_len_q.delete();
        @(posedge clk);
        @(negedge clk);
        check("abort_tx", 32'(bus.TX), 32'd1);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_state", 32'(bus.db_estado), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        send(16'h7FFF, 16'h8001);

        repeat (5) @(negedge clk);
        check("bytes_left", 32'(exp_q.size()), 32'd0);
        check("packets_left", 32'(exp_len_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
